// File: rtl/univ_shift_reg_if.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_if
// Bundles the control, data and status signals of the universal shift
// register so the register and its user connect through one port.
//
//   en         : clock enable, freezes all state when low
//   mode       : operation select
//   d          : parallel load data
//   sin_r      : serial bit entering at the MSB on a right shift
//   sin_l      : serial bit entering at the LSB on a left shift
//   start      : begin an automatic burst of shift_cnt shifts
//   shift_cnt  : number of shifts in a burst
//   q          : register contents
//   sout_r     : q[0]
//   sout_l     : q[WIDTH-1]
//   busy       : burst in progress
//   done       : one-cycle pulse when a burst finishes
//
// Modports: master drives the controls, slave is the register itself.
// ---------------------------------------------------------------------------
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic             start;
    logic [CNT_W-1:0] shift_cnt;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sin_r, sin_l, start, shift_cnt,
        input  q, sout_r, sout_l, busy, done
    );

    modport slave (
        input  en, mode, d, sin_r, sin_l, start, shift_cnt,
        output q, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal register: hold, serial shift left/right, rotate,
// parallel load and clear, plus an auto-burst mode where one start command
// performs shift_cnt shifts with a busy/done handshake.
//
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   bus   : univ_shift_reg_if slave modport (controls in, q/serial/status out)
// ---------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    univ_shift_reg_if.slave  bus
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_t            lat_mode_q, lat_mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    mode_t            in_mode;

    assign in_mode = mode_t'(bus.mode);

    // Next register value for one operation; hold and the reserved code
    // both fall through to the default.
    function automatic logic [WIDTH-1:0] apply_op(
        input mode_t            op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] load_val,
        input logic             sr,
        input logic             sl
    );
        logic [WIDTH-1:0] res;
        case (op)
            MODE_SHR:  res = {sr, cur[WIDTH-1:1]};
            MODE_SHL:  res = {cur[WIDTH-2:0], sl};
            MODE_LOAD: res = load_val;
            MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_CLR:  res = '0;
            default:   res = cur;
        endcase
        return res;
    endfunction

    function automatic logic is_shift(input mode_t m);
        return (m == MODE_SHR) || (m == MODE_SHL) ||
               (m == MODE_ROR) || (m == MODE_ROL);
    endfunction

    // State register. done is updated even when en is low so that the
    // completion pulse never stretches beyond one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lat_mode_q <= MODE_HOLD;
            q_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_mode_q <= lat_mode_d;
            q_q        <= q_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic. The accepting edge (E0) of a burst only latches the
    // mode and count; the shifts happen on the following enabled edges, and
    // the edge that takes the counter from 1 to 0 ends the burst.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_mode_d = lat_mode_q;
        q_d        = q_q;
        done_d     = 1'b0;

        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.start && is_shift(in_mode)) begin
                        if (bus.shift_cnt != '0) begin
                            lat_mode_d = in_mode;
                            cnt_d      = bus.shift_cnt;
                            state_d    = BUSY;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        q_d = apply_op(in_mode, q_q, bus.d, bus.sin_r, bus.sin_l);
                    end
                end
                BUSY: begin
                    q_d   = apply_op(lat_mode_q, q_q, bus.d, bus.sin_r, bus.sin_l);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.q      = q_q;
    assign bus.sout_r = q_q[0];
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.busy   = (state_q == BUSY);
    assign bus.done   = done_q;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register, the successor to the fixed 4-bit parallel-in/parallel-out register.
- Generalised in width.
- Adds serial-in/serial-out, left/right shift, rotate, synchronous clear and hold.
- Adds an auto-burst mode: a single start command performs N shifts with a busy/done handshake.
- Used as a serialiser/deserialiser and as a general datapath register.

Parameters:
WIDTH, 8, register width in bits (≥2)
CNT_W, 4, width of burst shift-count input; max burst = 2^CNT_W-1

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
en  input  1  clock enable; gates all state updates including burst progress
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
sin_r  input  1  serial input entering at MSB on right shift
sin_l  input  1  serial input entering at LSB on left shift
start  input  1  begin burst of shift_cnt shifts using current mode
shift_cnt  input  CNT_W  number of shifts in burst
q  output  WIDTH  register contents (parallel out)
sout_r  output  1  q[0], combinational from register
sout_l  output  1  q[WIDTH-1], combinational from register
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rstn=0, asynchronous): q=0, busy=0, done=0, internal counter=0, state=IDLE. Reset takes effect immediately, including mid-burst. Reset release is synchronous to the next edge.
- Mode encoding, applied at a rising edge with en=1:
  - 000 hold
  - 001 shift right: q<={sin_r,q[W-1:1]}
  - 010 shift left: q<={q[W-2:0],sin_l}
  - 011 load: q<=d
  - 100 rotate right: q<={q[0],q[W-1:1]}
  - 101 rotate left: q<={q[W-2:0],q[W-1]}
  - 110 clear: q<=0
  - 111 hold (reserved)
- Latency: one edge; q reflects the operation after the edge on which it is sampled.
- en=0: q, counter, state and the latched mode are all frozen. done still deasserts after its one cycle.
- State machine IDLE/BUSY.
- IDLE:
  - Normal operation per mode each en edge.
  - start=1 with mode in {001,010,100,101} and shift_cnt>0: latch the mode and load counter=shift_cnt. No shift on this edge (E0). Go to BUSY; busy=1.
  - start=1 with shift_cnt=0 and a shift/rotate mode: no shift, stay IDLE, done=1 for the next cycle.
  - start=1 with a non-shift mode: start is ignored and the normal mode applies.
- BUSY:
  - Each en edge performs one latched-mode shift and decrements the counter.
  - mode, d and start inputs are ignored. sin_r/sin_l are sampled live on each shift.
  - The edge that decrements the counter 1→0 returns to IDLE, clears busy and sets done=1 for exactly one cycle.
- Burst of N shifts: shifts on en edges E1..EN; busy high from after E0 through EN; done high in the cycle after EN.
- A start arriving in the same cycle that done is high is accepted as a new burst (back-to-back).
- busy and done are registered outputs.

Test Plan:
1. WIDTH=8: reset, then mode=011 d=8'hA5 one edge → q=8'hA5, sout_r=1, sout_l=1; then mode=000 for 3 edges → q stays 8'hA5.
2. From q=8'hA5, mode=001 sin_r=1 for two edges → q=8'hD2 then 8'hE9. Then mode=010 sin_l=0 one edge → q=8'hD2.
3. q=8'h81, mode=101, start=1 shift_cnt=3 → busy=1 for 3 cycles, q=8'h03,8'h06,8'h0C, then busy=0 and done=1 for exactly 1 cycle. Driving mode=011 during busy does not alter q.
4. Burst of 4 rotate-right from 8'h01 with en=0 for 2 cycles after the second shift → q holds 8'h40 and busy stays 1 during the stall. Completes at 8'h10; done then pulses once.
5. rstn low mid-burst (after 2 of 5 shifts) → q=0, busy=0, done=0 immediately without waiting for a clock edge. After release, start with shift_cnt=0 → no shift, busy stays 0, done=1 for one cycle.
6. Back-to-back: a second start (cnt=2) asserted in the done cycle of a first burst → accepted, busy rises the next cycle, two more shifts occur.
